// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one purely combinational ALU between two requesters. Round-robin
//   grant, valid/ready accept per requester, operands held on the ALU inputs
//   for the op latency (multi-cycle for multiply), and one tagged response.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready         request handshake, N = 0,1
//   reqN_rs1 / reqN_rs2 / reqN_op   request operands and opcode
//   alu_rs1 / alu_rs2 / alu_opcode  registered ALU inputs
//   alu_result                      combinational ALU output
//   rsp_valid / rsp_ready           response handshake
//   rsp_data / rsp_id               captured result and issuing requester
//   rsp_err                         only with ALU_ARB_OPCHECK_EN: opcode outside 000000-000011
//
// Optional feature macro: ALU_ARB_OPCHECK_EN
module alu_req_arbiter #(
  parameter int MUL_CYCLES = 3,
  parameter int ALU_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ALU_W-1:0] req0_rs1,
  input  logic [ALU_W-1:0] req0_rs2,
  input  logic [5:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ALU_W-1:0] req1_rs1,
  input  logic [ALU_W-1:0] req1_rs2,
  input  logic [5:0]       req1_op,
  output logic [ALU_W-1:0] alu_rs1,
  output logic [ALU_W-1:0] alu_rs2,
  output logic [5:0]       alu_opcode,
  input  logic [ALU_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_data,
  output logic             rsp_id
`ifdef ALU_ARB_OPCHECK_EN
  ,
  output logic             rsp_err
`endif
);

  localparam int         MUL_EFF = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int         CNT_W   = (MUL_EFF > 1) ? $clog2(MUL_EFF) : 1;
  localparam logic [5:0] OP_MUL  = 6'b000010;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ALU_W-1:0] rs1_q;
  logic [ALU_W-1:0] rs2_q;
  logic [5:0]       op_q;
  logic             rsp_valid_q;
  logic [ALU_W-1:0] rsp_data_q;
  logic             rsp_id_q;
`ifdef ALU_ARB_OPCHECK_EN
  logic             rsp_err_q;
  logic             op_err;
`endif

  logic             any_valid;
  logic             grant;
  logic             accept;
  logic [ALU_W-1:0] sel_rs1;
  logic [ALU_W-1:0] sel_rs2;
  logic [5:0]       sel_op;

  // Tie goes to the requester that did not win last; ready is gated by rst_n
  // so nothing appears accepted while reset is held.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    accept     = rst_n && (state_q == IDLE) && any_valid;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_rs1    = grant ? req1_rs1 : req0_rs1;
    sel_rs2    = grant ? req1_rs2 : req0_rs2;
    sel_op     = grant ? req1_op  : req0_op;
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign op_err = |op_q[5:2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            rs1_q        <= sel_rs1;
            rs2_q        <= sel_rs2;
            op_q         <= sel_op;
            rsp_id_q     <= grant;
            last_grant_q <= grant;
            cnt_q        <= (sel_op == OP_MUL) ? CNT_W'(MUL_EFF - 1) : '0;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
`ifdef ALU_ARB_OPCHECK_EN
            rsp_data_q <= op_err ? '0 : alu_result;
            rsp_err_q  <= op_err;
`else
            rsp_data_q <= alu_result;
`endif
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_rs1    = rs1_q;
  assign alu_rs2    = rs2_q;
  assign alu_opcode = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
//   Bench for alu_req_arbiter with a behavioural combinational ALU stub
//   (000000 add, 000001 sub, 000010 mul, 000011 nor, others 0).
//   Honours ALU_ARB_OPCHECK_EN when defined.
module tb_alu_req_arbiter;

  localparam int MUL_CYCLES = 3;
  localparam int ALU_W      = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [ALU_W-1:0] req0_rs1 = '0;
  logic [ALU_W-1:0] req0_rs2 = '0;
  logic [5:0]       req0_op = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [ALU_W-1:0] req1_rs1 = '0;
  logic [ALU_W-1:0] req1_rs2 = '0;
  logic [5:0]       req1_op = '0;
  logic [ALU_W-1:0] alu_rs1;
  logic [ALU_W-1:0] alu_rs2;
  logic [5:0]       alu_opcode;
  logic [ALU_W-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [ALU_W-1:0] rsp_data;
  logic             rsp_id;
`ifdef ALU_ARB_OPCHECK_EN
  logic             rsp_err;
`endif

  typedef struct {
    logic             id;
    logic [ALU_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ALU_W-1:0] alu_ref(input logic [5:0] op,
                                               input logic [ALU_W-1:0] a,
                                               input logic [ALU_W-1:0] b);
    case (op)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b000010: return a * b;
      6'b000011: return ~(a | b);
      default:   return '0;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic id, input logic [5:0] op,
                                  input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b);
    exp_t e;
    e.id   = id;
    e.err  = (op[5:2] != 4'b0000);
    e.data = e.err ? '0 : alu_ref(op, a, b);
    return e;
  endfunction

  assign alu_result = alu_ref(alu_opcode, alu_rs1, alu_rs2);

  alu_req_arbiter #(
    .MUL_CYCLES(MUL_CYCLES),
    .ALU_W     (ALU_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_rs1  (req0_rs1),
    .req0_rs2  (req0_rs2),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_rs1  (req1_rs1),
    .req1_rs2  (req1_rs2),
    .req1_op   (req1_op),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef ALU_ARB_OPCHECK_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on every response handshake, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            errors++;
            $display("FAIL rsp_data: got id=%0d data=%h, required id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
          end
`ifdef ALU_ARB_OPCHECK_EN
          checks++;
          if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_err: got %0b, required %0b", rsp_err, e.err);
          end
`endif
        end
      end
    end
  endtask

  task automatic drop(input logic id);
    if (id == 1'b0) begin
      req0_valid = 1'b0; req0_op = 6'h3f; req0_rs1 = $urandom; req0_rs2 = $urandom;
    end else begin
      req1_valid = 1'b0; req1_op = 6'h3f; req1_rs1 = $urandom; req1_rs2 = $urandom;
    end
  endtask

  // Drives one request, waits (bounded) for its accept edge, then scrambles the inputs.
  task automatic send(input logic id, input logic [5:0] op, input logic [ALU_W-1:0] a,
                      input logic [ALU_W-1:0] b, input bit push, output int acc_cyc);
    int n = 0;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_rs1 = a; req0_rs2 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_rs1 = a; req1_rs2 = b;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL accept_timeout: req%0d_ready got 0, required 1", id);
    end else if (push) begin
      sb.push_back(mk_exp(id, op, a, b));
    end
    tick();
    acc_cyc = cyc;
    drop(id);
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", tag, lat, exp_lat);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n      = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b%0b, required 00", req0_ready, req1_ready);
    end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%0b d=%h id=%0b, required 0/0/0", rsp_valid, rsp_data, rsp_id);
    end
    checks++;
    if (alu_rs1 !== '0 || alu_rs2 !== '0 || alu_opcode !== '0) begin
      errors++;
      $display("FAIL reset_alu: got %h %h %h, required zeros", alu_rs1, alu_rs2, alu_opcode);
    end
`ifdef ALU_ARB_OPCHECK_EN
    checks++;
    if (rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %0b, required 0", rsp_err);
    end
`endif
    drop(1'b0);
    drop(1'b1);
    rst_n = 1'b1;
    tick();
  endtask

  // Both requesters valid together; checks who wins first and that grants never overlap.
  task automatic tie(input logic [5:0] op0, input logic [ALU_W-1:0] a0, input logic [ALU_W-1:0] b0,
                     input logic [5:0] op1, input logic [ALU_W-1:0] a1, input logic [ALU_W-1:0] b1,
                     input logic first_exp, input string tag);
    bit d0 = 0;
    bit d1 = 0;
    bit seen = 0;
    int n = 0;
    req0_valid = 1'b1; req0_op = op0; req0_rs1 = a0; req0_rs2 = b0;
    req1_valid = 1'b1; req1_op = op1; req1_rs1 = a1; req1_rs2 = b1;
    #1;
    while (!(d0 && d1) && n < 40) begin
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL %s_both_ready: got 11, required at most one", tag);
      end
      if (req0_ready || req1_ready) begin
        if (!seen) begin
          seen = 1;
          checks++;
          if (req1_ready !== first_exp) begin
            errors++;
            $display("FAIL %s_first_grant: got req%0d, required req%0d", tag, req1_ready, first_exp);
          end
        end
        if (req0_ready) begin d0 = 1; sb.push_back(mk_exp(1'b0, op0, a0, b0)); end
        if (req1_ready) begin d1 = 1; sb.push_back(mk_exp(1'b1, op1, a1, b1)); end
        tick();
        if (d0 && req0_valid) drop(1'b0);
        if (d1 && req1_valid) drop(1'b1);
      end else begin
        tick();
      end
      n++;
    end
    checks++;
    if (!(d0 && d1)) begin
      errors++;
      $display("FAIL %s_timeout: accepted %0b%0b, required 11", tag, d1, d0);
      drop(1'b0);
      drop(1'b1);
    end
  endtask

  task automatic test_tie();
    tie(6'b000001, 32'd10, 32'd3, 6'b000011, 32'd0, 32'd0, 1'b0, "tie1");
    drain();
    tie(6'b000000, 32'd1, 32'd1, 6'b000001, 32'd5, 32'd6, 1'b0, "tie2");
    drain();
  endtask

  task automatic test_add();
    int acc;
    req0_valid = 1'b1; req0_op = 6'b000000; req0_rs1 = 32'd5; req0_rs2 = 32'd7;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_ready_same_cycle: got %0b%0b, required 01", req1_ready, req0_ready);
    end
    sb.push_back('{id: 1'b0, data: 32'd12, err: 1'b0});
    tick();
    acc = cyc;
    drop(1'b0);
    wait_rsp("add", 1);
    drain();
  endtask

  task automatic test_mul();
    int acc;
    bit bad = 0;
    sb.push_back('{id: 1'b1, data: 32'h0001_0000, err: 1'b0});
    send(1'b1, 6'b000010, 32'h0001_0000, 32'h0001_0001, 1'b0, acc);
    for (int i = 0; i < MUL_CYCLES; i++) begin
      if (rsp_valid !== 1'b0 || alu_rs1 !== 32'h0001_0000 || alu_rs2 !== 32'h0001_0001 ||
          alu_opcode !== 6'b000010)
        bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mul_hold: alu inputs or rsp_valid moved during exec, required %h %h 02 and v=0",
               32'h0001_0000, 32'h0001_0001);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL mul_latency: rsp_valid got %0b at %0d cycles, required 1", rsp_valid, MUL_CYCLES);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc;
    bit bad = 0;
    rsp_ready = 1'b0;
    send(1'b0, 6'b000000, 32'd1, 32'd2, 1'b1, acc);
    wait_rsp("bp", 1);
    req0_valid = 1'b1; req0_op = 6'b000001; req0_rs1 = 32'd20; req0_rs2 = 32'd5;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 1'b0 || req0_ready !== 1'b0)
        bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got v=%0b d=%h rdy=%0b, required v=1 d=3 rdy=0", rsp_valid, rsp_data, req0_ready);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: req0_ready got %0b, required 1", req0_ready);
    end
    sb.push_back('{id: 1'b0, data: 32'd15, err: 1'b0});
    tick();
    drop(1'b0);
    drain();
  endtask

  task automatic test_undef();
    int acc;
    send(1'b0, 6'b000111, 32'd9, 32'd0, 1'b1, acc);
    wait_rsp("undef", 1);
    tick();
    send(1'b0, 6'b000000, 32'd3, 32'd4, 1'b1, acc);
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    int prev;
    logic [5:0] op;
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       op = 6'b000000;
        1:       op = 6'b000001;
        default: op = 6'b000011;
      endcase
      send(i[0], op, $urandom, $urandom, 1'b1, acc);
      if (i > 0) begin
        checks++;
        if (acc - prev !== 3) begin
          errors++;
          $display("FAIL b2b_interval: got %0d cycles, required 3", acc - prev);
        end
      end
      prev = acc;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int acc;
    bit bad = 0;
    send(1'b1, 6'b000010, 32'd3, 32'd4, 1'b0, acc);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 1'b0 || alu_rs1 !== '0 ||
        alu_rs2 !== '0 || alu_opcode !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got v=%0b d=%h id=%0b alu=%h %h %h, required zeros",
               rsp_valid, rsp_data, rsp_id, alu_rs1, alu_rs2, alu_opcode);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_stale: rsp_valid got 1 after reset, required 0");
    end
    tie(6'b000000, 32'd100, 32'd1, 6'b000000, 32'd200, 32'd2, 1'b0, "midrst_tie");
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_tie();
    test_add();
    test_mul();
    test_backpressure();
    test_undef();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
